// File: rtl/gex_pkg.sv
// rtl/gex_pkg.sv - shared fixed-point widths, limits and state encoding for gex paths
package gex_pkg;
    localparam int DEF_INTEGER_WIDTH   = 32;
    localparam int DEF_DATA_WIDTH_FRAC = 32;
    localparam int DEF_DATA_WIDTH      = DEF_INTEGER_WIDTH + DEF_DATA_WIDTH_FRAC;

    localparam logic [DEF_DATA_WIDTH-1:0] GEX_MAX = {1'b0, {(DEF_DATA_WIDTH-1){1'b1}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } gex_state_e;
endpackage

// File: rtl/gex_sat_adder.sv
// rtl/gex_sat_adder.sv - combinational saturating adder clamping to [0, max positive]
module gex_sat_adder
    import gex_pkg::*;
#(
    parameter int WIDTH = DEF_DATA_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             sat
);
    logic [WIDTH:0] wide;

    // One extra bit holds the exact signed sum of two WIDTH-bit operands.
    always_comb begin
        wide = {a[WIDTH-1], a} + {b[WIDTH-1], b};
        sum  = wide[WIDTH-1:0];
        sat  = 1'b0;
        if (wide[WIDTH]) begin
            sum = '0;
            sat = 1'b1;
        end else if (wide[WIDTH-1]) begin
            sum = {1'b0, {(WIDTH-1){1'b1}}};
            sat = 1'b1;
        end
    end
endmodule

// File: rtl/gex_accumulate_unit.sv
// rtl/gex_accumulate_unit.sv - per-timestep saturating accumulation of synaptic weights into gex
module gex_accumulate_unit
    import gex_pkg::*;
#(
    parameter int INTEGER_WIDTH   = DEF_INTEGER_WIDTH,
    parameter int DATA_WIDTH_FRAC = DEF_DATA_WIDTH_FRAC,
    parameter int DATA_WIDTH      = INTEGER_WIDTH + DATA_WIDTH_FRAC,
    parameter int COUNT_WIDTH     = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [DATA_WIDTH-1:0]  gex_in,
    input  logic [DATA_WIDTH-1:0]  weight,
    input  logic                   weight_valid,
    input  logic                   weight_last,
    output logic                   weight_ready,
    output logic [DATA_WIDTH-1:0]  gex_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [COUNT_WIDTH-1:0] event_count,
    output logic                   saturated
);
    gex_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0]  acc_q;
    logic [COUNT_WIDTH-1:0] cnt_q;
    logic                   sat_q;

    logic [DATA_WIDTH-1:0]  add_a, add_b, add_sum;
    logic                   add_sat;
    logic                   load, beat;

    assign load = (state_q == IDLE) && start;
    assign beat = (state_q == ACCUM) && weight_valid;

    // In IDLE the adder computes 0 + gex_in, which doubles as the load clamp.
    assign add_a = (state_q == IDLE) ? '0 : acc_q;
    assign add_b = (state_q == IDLE) ? gex_in : weight;

    gex_sat_adder #(.WIDTH(DATA_WIDTH)) u_sat_adder (
        .a   (add_a),
        .b   (add_b),
        .sum (add_sum),
        .sat (add_sat)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ACCUM;
            ACCUM:   if (beat && weight_last) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load) begin
                acc_q <= add_sum;
                cnt_q <= '0;
                sat_q <= add_sat;
            end else if (beat) begin
                acc_q <= add_sum;
                if (cnt_q != {COUNT_WIDTH{1'b1}}) begin
                    cnt_q <= cnt_q + COUNT_WIDTH'(1);
                end
                sat_q <= sat_q | add_sat;
            end
        end
    end

    assign weight_ready = (state_q == ACCUM);
    assign out_valid    = (state_q == DONE);
    assign gex_out      = acc_q;
    assign event_count  = cnt_q;
    assign saturated    = sat_q;
endmodule

// File: tb/tb_gex_accumulate_unit.sv
// tb/tb_gex_accumulate_unit.sv - randomized self-checking bench for gex_accumulate_unit
module tb_gex_accumulate_unit;
    localparam int DW = 64;
    localparam int CW = 4;
    localparam logic signed [DW+1:0] MAXV = {3'b000, {(DW-1){1'b1}}};

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [DW-1:0] gex_in;
    logic [DW-1:0] weight;
    logic          weight_valid;
    logic          weight_last;
    logic          weight_ready;
    logic [DW-1:0] gex_out;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] event_count;
    logic          saturated;

    gex_accumulate_unit #(.INTEGER_WIDTH(32), .DATA_WIDTH_FRAC(32), .COUNT_WIDTH(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .gex_in       (gex_in),
        .weight       (weight),
        .weight_valid (weight_valid),
        .weight_last  (weight_last),
        .weight_ready (weight_ready),
        .gex_out      (gex_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .event_count  (event_count),
        .saturated    (saturated)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: exact signed arithmetic on a wide integer, clamped per beat.
    logic signed [DW+1:0] m_acc;
    bit                   m_sat;
    int                   m_cnt;
    logic [DW-1:0]        wq[$];

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_gex();
        return m_acc[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] exp_cnt();
        return (m_cnt > 15) ? 64'd15 : 64'(m_cnt);
    endfunction

    function automatic logic [DW-1:0] rnd64();
        return {32'($urandom), 32'($urandom)};
    endfunction

    function automatic logic [DW-1:0] rnd_weight();
        logic [DW-1:0] v;
        case ($urandom_range(0, 4))
            0:       v = {32'($urandom_range(0, 3)), 32'($urandom)};
            1:       v = -{32'($urandom_range(0, 3)), 32'($urandom)};
            2:       v = '0;
            3:       v = rnd64();
            default: v = {32'($urandom_range(0, 100)), 32'($urandom)};
        endcase
        return v;
    endfunction

    task automatic model_add(input logic [DW-1:0] w);
        m_acc = m_acc + $signed({{2{w[DW-1]}}, w});
        if (m_acc > MAXV) begin
            m_acc = MAXV;
            m_sat = 1'b1;
        end else if (m_acc < 0) begin
            m_acc = '0;
            m_sat = 1'b1;
        end
        m_cnt++;
    endtask

    task automatic do_start(input logic [DW-1:0] g);
        chk("idle_wready", 64'(weight_ready), 64'd0);
        chk("idle_ovalid", 64'(out_valid), 64'd0);
        start  = 1'b1;
        gex_in = g;
        @(posedge clk); #1;
        start  = 1'b0;
        gex_in = rnd64();
        m_acc  = '0;
        m_sat  = 1'b0;
        m_cnt  = -1;
        model_add(g);
        m_cnt  = 0;
        chk("wready_after_start", 64'(weight_ready), 64'd1);
    endtask

    task automatic do_beat(input logic [DW-1:0] w, input bit last, input int maxgap);
        int gaps = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
        for (int i = 0; i < gaps; i++) begin
            weight_valid = 1'b0;
            weight       = rnd64();
            weight_last  = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            chk("gap_cnt", 64'(event_count), exp_cnt());
            chk("gap_gex", gex_out, exp_gex());
        end
        weight_valid = 1'b1;
        weight       = w;
        weight_last  = last;
        chk("beat_wready", 64'(weight_ready), 64'd1);
        @(posedge clk); #1;
        weight_valid = 1'b0;
        weight_last  = 1'b0;
        model_add(w);
    endtask

    task automatic check_result(input string tag);
        chk({tag, "_ovalid"}, 64'(out_valid), 64'd1);
        chk({tag, "_gex"}, gex_out, exp_gex());
        chk({tag, "_cnt"}, 64'(event_count), exp_cnt());
        chk({tag, "_sat"}, 64'(saturated), 64'(m_sat));
    endtask

    task automatic drain(input int hold, input bit extra_start, input bit start_on_accept);
        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            if (extra_start && i == 1) begin
                start  = 1'b1;
                gex_in = rnd64();
            end
            @(posedge clk); #1;
            start = 1'b0;
            chk("hold_ovalid", 64'(out_valid), 64'd1);
            chk("hold_gex", gex_out, exp_gex());
            chk("hold_wready", 64'(weight_ready), 64'd0);
        end
        out_ready = 1'b1;
        start     = start_on_accept;
        gex_in    = rnd64();
        @(posedge clk); #1;
        out_ready = 1'b0;
        start     = 1'b0;
        chk("post_ovalid", 64'(out_valid), 64'd0);
        chk("post_wready", 64'(weight_ready), 64'd0);
        chk("post_gex", gex_out, exp_gex());
        chk("post_cnt", 64'(event_count), exp_cnt());
    endtask

    task automatic timestep(input string tag, input logic [DW-1:0] g, input int maxgap,
                            input int hold, input bit extra_start);
        do_start(g);
        for (int i = 0; i < wq.size(); i++) begin
            do_beat(wq[i], i == wq.size() - 1, maxgap);
        end
        check_result(tag);
        drain(hold, extra_start, 1'($urandom_range(0, 1)));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; gex_in = '0; weight = '0;
        weight_valid = 1'b0; weight_last = 1'b0; out_ready = 1'b0;
        #1;
        chk("rst_gex", gex_out, 64'd0);
        chk("rst_ovalid", 64'(out_valid), 64'd0);
        chk("rst_wready", 64'(weight_ready), 64'd0);
        chk("rst_cnt", 64'(event_count), 64'd0);
        chk("rst_sat", 64'(saturated), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        wq = '{64'h00000000_40000000, 64'h00000000_40000000};
        timestep("t_basic", 64'h00000001_80000000, 0, 0, 1'b0);
        chk("t_basic_const", gex_out, 64'h00000002_00000000);

        wq = '{64'h00000002_00000000};
        timestep("t_max", 64'h7FFFFFFF_00000000, 0, 0, 1'b0);
        chk("t_max_const", gex_out, 64'h7FFFFFFF_FFFFFFFF);
        chk("t_max_sat", 64'(saturated), 64'd1);

        wq = '{64'hFFFFFFFD_00000000};
        timestep("t_neg", 64'h00000001_00000000, 0, 0, 1'b0);
        chk("t_neg_const", gex_out, 64'd0);
        wq = '{64'd0};
        timestep("t_zero", 64'h00000001_00000000, 0, 0, 1'b0);
        chk("t_zero_sat", 64'(saturated), 64'd0);

        wq = '{rnd_weight(), rnd_weight(), rnd_weight(), rnd_weight()};
        timestep("t_gaps", 64'h00000003_00000000, 3, 5, 1'b1);

        wq = '{64'hFFFFFFFF_00000000};
        timestep("t_gin_neg", 64'hFFFFFFFF_00000000, 0, 0, 1'b0);

        // Reset after 3 of 5 beats must drop everything without a result.
        do_start(64'h00000005_00000000);
        for (int i = 0; i < 3; i++) do_beat(64'h00000001_00000000, 1'b0, 0);
        rst_n = 1'b0;
        #2;
        chk("midrst_gex", gex_out, 64'd0);
        chk("midrst_ovalid", 64'(out_valid), 64'd0);
        chk("midrst_wready", 64'(weight_ready), 64'd0);
        chk("midrst_cnt", 64'(event_count), 64'd0);
        chk("midrst_sat", 64'(saturated), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        weight_valid = 1'b1; weight_last = 1'b1;
        @(posedge clk); #1;
        weight_valid = 1'b0; weight_last = 1'b0;
        chk("after_rst_ovalid", 64'(out_valid), 64'd0);
        wq = '{64'h00000000_80000000, 64'h00000000_80000000};
        timestep("t_fresh", 64'h00000001_00000000, 1, 1, 1'b0);

        wq.delete();
        for (int i = 0; i < 19; i++) wq.push_back({32'($urandom_range(0, 2)), 32'($urandom)});
        timestep("t_cntsat", 64'h00000000_10000000, 0, 0, 1'b0);
        chk("t_cntsat_const", 64'(event_count), 64'd15);

        for (int t = 0; t < 25; t++) begin
            logic [DW-1:0] g;
            int nb = $urandom_range(1, 8);
            wq.delete();
            for (int i = 0; i < nb; i++) wq.push_back(rnd_weight());
            g = ($urandom_range(0, 4) == 0) ? rnd64() : {32'($urandom_range(0, 50)), 32'($urandom)};
            timestep("t_rand", g, 2, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/gex_accumulate_unit.md
# gex_accumulate_unit

Sequential excitatory-conductance accumulator: the increasing direction of the gex dynamics, complementing the combinational decay (leak) path. Per neuron per timestep, it loads the leaked gex value, accepts a valid/ready stream of synaptic weights, and saturating-adds each weight in the shared signed Q(INTEGER_WIDTH).(DATA_WIDTH_FRAC) format. It then presents the updated gex with a valid/ready output handshake. It sits between the synaptic event router and the neuron state writeback.

## Interface
- INTEGER_WIDTH, 32, integer bits of the fixed-point format
- DATA_WIDTH_FRAC, 32, fractional bits
- DATA_WIDTH, INTEGER_WIDTH+DATA_WIDTH_FRAC, total word width
- COUNT_WIDTH, 16, event counter width

- Clock  in  1  single clock; all state on rising edge
- Reset  in  1  asynchronous, active-low reset
- Start  in  1  one-cycle pulse that begins a timestep; sampled only in IDLE
- gexIn  in  DATA_WIDTH signed  leaked gex; captured on accepted Start
- Weight  in  DATA_WIDTH signed  synaptic weight, same Q format
- WeightValid  in  1  weight beat valid
- WeightLast  in  1  marks final beat of timestep
- WeightReady  out  1  accumulator accepts a beat
- gexOut  out  DATA_WIDTH signed  accumulated gex; stable while OutValid
- OutValid  out  1  result available
- OutReady  in  1  consumer accepts result
- EventCount  out  COUNT_WIDTH  beats accepted this timestep
- Saturated  out  1  sticky; a clamp occurred this timestep

## Operation
- States: IDLE, ACCUM, DONE.
- IDLE: WeightReady=0, OutValid=0.
  - Start=1 -> acc=clamp(gexIn), EventCount=0, Saturated=0 -> ACCUM.
  - Negative gexIn loads 0 and sets Saturated.
- ACCUM: WeightReady=1. Each beat (WeightValid&WeightReady) does:
  - acc=sat_add(acc,Weight);
  - EventCount+1, holding at all-ones;
  - if WeightLast -> DONE.
  - WeightValid=0 leaves everything unchanged.
- DONE: OutValid=1, gexOut=acc.
  - OutReady=1 -> IDLE.
  - WeightReady=0.
- Start is ignored outside IDLE, including the DONE cycle in which OutReady is accepted.
- Empty timestep: the sender issues one beat with Weight=0, WeightLast=1.
- sat_add: sign-extended sum in DATA_WIDTH+1 bits.
  - Sum > 2^(DATA_WIDTH-1)-1 -> max positive, Saturated=1.
  - Sum < 0 -> 0, Saturated=1. gex is never negative.
  - Otherwise the exact sum; no rounding, fractional bits kept.
- gexOut, EventCount and Saturated hold their values in IDLE until the next accepted Start.

## Timing
- Reset asserted:
  - state=IDLE;
  - gexOut=0, OutValid=0, WeightReady=0, EventCount=0, Saturated=0;
  - takes effect immediately; deassertion is synchronised by the system.
- Reset mid-ACCUM or mid-DONE: the partial result is discarded and no OutValid is produced.
- Start in cycle t -> WeightReady=1 from cycle t+1.
- Throughput: one beat per cycle.
- Last beat accepted in cycle k -> OutValid=1 and final gexOut in cycle k+1 (1-cycle latency).
- OutValid stays high, with gexOut unchanged, until OutReady is sampled high.
- Back-to-back: OutReady accepted in cycle m -> IDLE in m+1; the next Start is accepted in m+1, and the next beat in m+2.
- All outputs are registered; no combinational input-to-output path.

## Structure
- Shared package gex_pkg:
  - INTEGER_WIDTH/DATA_WIDTH_FRAC defaults;
  - GEX_MAX constant (max positive);
  - state enum {IDLE, ACCUM, DONE}.
- Sub-module gex_sat_adder: combinational saturating adder; outputs sum and sat flag. It is reused by other conductance paths.
- Top: FSM, acc register, counter, sticky flag.

## Test plan
- Start with gexIn=1.5 (0x00000001_80000000). Beats 0.25, 0.25 (Last) -> gexOut=2.0, EventCount=2, Saturated=0, OutValid exactly one cycle after Last.
- gexIn=0x7FFFFFFF_00000000, Weight=2.0 (Last) -> gexOut=0x7FFFFFFF_FFFFFFFF, Saturated=1.
- gexIn=1.0, Weight=-3.0 (Last) -> gexOut=0, Saturated=1. A following timestep with gexIn=1.0 and Weight=0 (Last) -> Saturated=0.
- Gaps in WeightValid, with OutReady held low for 5 cycles:
  - gexOut stable; WeightReady=0;
  - an extra Start is ignored;
  - Start on the cycle after the OutReady handshake is accepted.
- Reset pulsed low after 3 of 5 beats -> all outputs 0 immediately; no OutValid; a fresh timestep then works normally.
- 2^COUNT_WIDTH+3 beats (COUNT_WIDTH=4 build) -> EventCount holds at 15; the sum is still exact.
